vga_sync: RTL and testbench
===========================

VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- bus_pixeles, 10, coordinate counter width.
- H_DISPLAY, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync width in pixels.
- H_BACK, 48, horizontal back porch in pixels.
- V_DISPLAY, 480, visible lines per frame.
- V_FRONT, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BACK, 33, vertical back porch in lines.
- TICK_DIV, 4, clk cycles per pixel.

REQ-002 Ports (name, direction, width, meaning), one per line, clock and reset first:
- clk, input, 1, single system clock (100 MHz); all logic on its rising edge.
- reset, input, 1, synchronous, active-high.
- hsync, output, 1, horizontal sync, active-low.
- vsync, output, 1, vertical sync, active-low.
- video_on, output, 1, high while the current coordinate is in the visible area.
- p_tick, output, 1, one-clk pulse per pixel period.
- pixel_x, output, bus_pixeles, current column, 0..H_TOTAL-1.
- pixel_y, output, bus_pixeles, current line, 0..V_TOTAL-1.

Function
REQ-003 Derived constants:
- H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK = 800.
- V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK = 525.

REQ-004 Pixel-tick divider:
- Counts 0..TICK_DIV-1, then wraps to 0.
- p_tick is high for exactly the one clk in which the divider equals TICK_DIV-1.
- p_tick is low in every other clk.

REQ-005 Horizontal counter:
- Changes only in a clk where p_tick is high.
- Increments by 1.
- Wraps from H_TOTAL-1 to 0.

REQ-006 Vertical counter:
- Changes only in a clk where p_tick is high and the horizontal counter equals H_TOTAL-1.
- Increments by 1.
- Wraps from V_TOTAL-1 to 0.
- Frame end (h=799, v=524, p_tick high): both counters return to 0 on the same edge.

REQ-007 pixel_x and pixel_y equal the horizontal and vertical counters, driven directly from registers.

REQ-008 hsync:
- Registered.
- Low exactly while pixel_x is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], i.e. 656..751.
- High otherwise.
- Aligned to the same clk as the pixel_x value it decodes, with no extra cycle of lag.

REQ-009 vsync:
- Registered.
- Low exactly while pixel_y is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], i.e. 490..491.
- High otherwise.
- Same alignment rule as hsync.

REQ-010 video_on:
- High exactly when pixel_x < H_DISPLAY and pixel_y < V_DISPLAY; low otherwise.
- Same-cycle aligned with pixel_x and pixel_y.

REQ-011 Between p_tick pulses, pixel_x, pixel_y, hsync, vsync and video_on hold constant, so each pixel coordinate persists for exactly TICK_DIV clk cycles.

REQ-012 Counter widths are bus_pixeles bits. Values never exceed H_TOTAL-1 or V_TOTAL-1, so no overflow occurs.

Reset
REQ-013 While reset is high at a clk edge, the block loads:
- divider = 0, pixel_x = 0, pixel_y = 0, p_tick = 0;
- hsync = 1, vsync = 1;
- video_on = 1, consistent with coordinate (0,0).

REQ-014 Reset asserted mid-line or mid-frame:
- Takes effect on the next edge.
- Overrides any pending increment or wrap.
- No partial state survives.

REQ-015 After reset deasserts:
- The first p_tick occurs TICK_DIV clk cycles later.
- The first coordinate change, to pixel_x = 1, occurs on that tick.

Verification
REQ-016 The bench covers at least the following scenarios:
- Reset release: reset high for 3 clk, then low -> pixel_x=0, pixel_y=0, hsync=1, vsync=1, video_on=1; p_tick first high on the 4th clk after release; pixel_x=1 one edge later.
- Horizontal timing: run one full line -> exactly 800 p_ticks per line; hsync low for 96 consecutive pixels starting at pixel_x=656; video_on falls when pixel_x=640.
- Line wrap: at pixel_x=799 with p_tick -> pixel_x=0 and pixel_y increments by 1 on the same edge.
- Frame wrap and vsync: run a full frame -> exactly 525 lines, i.e. 420000 p_ticks (1680000 clk); vsync low only during lines 490-491; at (799,524) with p_tick both counters become 0 together.
- Mid-frame reset: assert reset at pixel_x=700, pixel_y=300 -> next edge gives all outputs at reset values (REQ-013); timing restarts per REQ-015.
- Continuous checker: assertion every clk that hsync, vsync and video_on match the decode of the current pixel_x and pixel_y (REQ-008 to REQ-010), and that p_tick never pulses in consecutive clk cycles.

Source files
------------

// File: rtl/vga_sync.sv
// rtl/vga_sync.sv - VGA timing generator: pixel-tick divider, h/v counters, registered sync and blanking
module vga_sync #(
    parameter int bus_pixeles = 10,
    parameter int H_DISPLAY   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_DISPLAY   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int TICK_DIV    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   video_on,
    output logic                   p_tick,
    output logic [bus_pixeles-1:0] pixel_x,
    output logic [bus_pixeles-1:0] pixel_y
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [DIV_W-1:0]       DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [bus_pixeles-1:0] H_LAST   = bus_pixeles'(H_TOTAL - 1);
    localparam logic [bus_pixeles-1:0] V_LAST   = bus_pixeles'(V_TOTAL - 1);
    localparam logic [bus_pixeles-1:0] H_VIS    = bus_pixeles'(H_DISPLAY);
    localparam logic [bus_pixeles-1:0] V_VIS    = bus_pixeles'(V_DISPLAY);
    localparam logic [bus_pixeles-1:0] HS_FIRST = bus_pixeles'(H_DISPLAY + H_FRONT);
    localparam logic [bus_pixeles-1:0] HS_LAST  = bus_pixeles'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [bus_pixeles-1:0] VS_FIRST = bus_pixeles'(V_DISPLAY + V_FRONT);
    localparam logic [bus_pixeles-1:0] VS_LAST  = bus_pixeles'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0]       div_q;
    logic [DIV_W-1:0]       div_next;
    logic                   tick_next;
    logic [bus_pixeles-1:0] h_next;
    logic [bus_pixeles-1:0] v_next;
    logic                   hsync_next;
    logic                   vsync_next;
    logic                   video_on_next;

    always_comb begin
        div_next = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        tick_next = (div_next == DIV_LAST);

        h_next = pixel_x;
        v_next = pixel_y;
        if (p_tick) begin
            if (pixel_x == H_LAST) begin
                h_next = '0;
                v_next = (pixel_y == V_LAST) ? '0 : pixel_y + 1'b1;
            end else begin
                h_next = pixel_x + 1'b1;
            end
        end

        // Decode the coordinate about to be loaded so the syncs land on the same edge as it.
        hsync_next    = !((h_next >= HS_FIRST) && (h_next <= HS_LAST));
        vsync_next    = !((v_next >= VS_FIRST) && (v_next <= VS_LAST));
        video_on_next = (h_next < H_VIS) && (v_next < V_VIS);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q    <= '0;
            p_tick   <= 1'b0;
            pixel_x  <= '0;
            pixel_y  <= '0;
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            video_on <= 1'b1;
        end else begin
            div_q    <= div_next;
            p_tick   <= tick_next;
            pixel_x  <= h_next;
            pixel_y  <= v_next;
            hsync    <= hsync_next;
            vsync    <= vsync_next;
            video_on <= video_on_next;
        end
    end

endmodule

// File: tb/tb_vga_sync.sv
// tb/tb_vga_sync.sv - self-checking bench for vga_sync with a short frame (12 lines of 800 pixels)
module tb_vga_sync;

    localparam int VT = 12;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       p_tick;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;
    bit started = 1'b0;
    logic prev_tick = 1'b0;

    vga_sync #(
        .V_DISPLAY(6),
        .V_FRONT  (2),
        .V_SYNC   (2),
        .V_BACK   (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .hsync   (hsync),
        .vsync   (vsync),
        .video_on(video_on),
        .p_tick  (p_tick),
        .pixel_x (pixel_x),
        .pixel_y (pixel_y)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Clocks elapsed since reset was last sampled high.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
        started <= 1'b1;
    end

    // Model: pixel index is the number of completed pixel periods; coordinates follow by division.
    always @(negedge clk) begin
        if (started) begin
            int unsigned n, x, y;
            logic pt, hs, vs, vo;
            n  = cyc / 4;
            x  = n % 800;
            y  = (n / 800) % VT;
            pt = ((cyc % 4) == 3);
            hs = !(x >= 656 && x <= 751);
            vs = !(y >= 8 && y <= 9);
            vo = (x < 640) && (y < 6);
            check("model", {8'd0, p_tick, pixel_x, pixel_y, hsync, vsync, video_on},
                  {8'd0, pt, x[9:0], y[9:0], hs, vs, vo});
            check("tick_back_to_back", {31'd0, prev_tick & p_tick}, 32'd0);
            prev_tick = p_tick;
        end
    end

    task automatic check_reset_state(input string name);
        check(name, {8'd0, p_tick, pixel_x, pixel_y, hsync, vsync, video_on},
              {8'd0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1});
    endtask

    task automatic check_restart(input string name);
        logic       pt_req [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [9:0] x_req  [4] = '{10'd0, 10'd0, 10'd0, 10'd1};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check({name, "_tick"}, {31'd0, p_tick}, {31'd0, pt_req[k]});
            check({name, "_x"}, {22'd0, pixel_x}, {22'd0, x_req[k]});
        end
    endtask

    initial begin
        int ticks, hs_low, hs_first, hs_last, vo_fall, vs_low, vs_min, vs_max;
        int saved_y;
        bit found;
        logic prev_vo;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset_hold");
        reset = 1'b0;
        check_restart("release");

        // One full line worth of clocks.
        ticks = 0; hs_low = 0; hs_first = -1; hs_last = -1; vo_fall = -1;
        prev_vo = video_on;
        for (int i = 0; i < 3200; i++) begin
            @(negedge clk);
            if (p_tick) ticks++;
            if (!hsync) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(pixel_x);
                hs_last = int'(pixel_x);
            end
            if (prev_vo && !video_on && vo_fall < 0) vo_fall = int'(pixel_x);
            prev_vo = video_on;
        end
        check("line_ticks", ticks, 800);
        check("hsync_low_pixels", hs_low / 4, 96);
        check("hsync_first_x", hs_first, 656);
        check("hsync_last_x", hs_last, 751);
        check("video_on_fall_x", vo_fall, 640);

        found = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            @(negedge clk);
            if (pixel_x == 10'd799 && p_tick) found = 1'b1;
        end
        check("line_end_reached", {31'd0, found}, 32'd1);
        saved_y = int'(pixel_y);
        @(negedge clk);
        check("line_wrap_x", {22'd0, pixel_x}, 32'd0);
        check("line_wrap_y", {22'd0, pixel_y}, saved_y + 1);

        found = 1'b0;
        for (int i = 0; i < 30000 && !found; i++) begin
            @(negedge clk);
            if (pixel_x == 10'd700 && pixel_y == 10'd7) found = 1'b1;
        end
        check("midframe_reached", {31'd0, found}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("midframe_reset");
        reset = 1'b0;
        check_restart("restart");

        // Full frame from the restart; the restart already produced the first tick.
        ticks = 1; vs_low = 0; vs_min = 1000; vs_max = -1;
        found = 1'b0;
        for (int i = 0; i < 40000 && !found; i++) begin
            @(negedge clk);
            if (p_tick) ticks++;
            if (!vsync) begin
                vs_low++;
                if (int'(pixel_y) < vs_min) vs_min = int'(pixel_y);
                if (int'(pixel_y) > vs_max) vs_max = int'(pixel_y);
            end
            if (pixel_x == 10'd799 && pixel_y == 10'(VT - 1) && p_tick) found = 1'b1;
        end
        check("frame_end_reached", {31'd0, found}, 32'd1);
        check("frame_ticks", ticks, 800 * VT);
        check("vsync_low_clks", vs_low, 2 * 800 * 4);
        check("vsync_first_line", vs_min, 8);
        check("vsync_last_line", vs_max, 9);
        @(negedge clk);
        check("frame_wrap_xy", {12'd0, pixel_x, pixel_y}, 32'd0);
        check("frame_wrap_syncs", {29'd0, hsync, vsync, video_on}, 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
